// File: rtl/sv_uart_pkg.sv
// Shared types and constants for the UART receive path.
package sv_uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_STOP2
  } rx_state_e;

  localparam int unsigned TUSER_FRAME_ERR  = 0;
  localparam int unsigned TUSER_PARITY_ERR = 1;

endpackage

// File: rtl/sv_uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full succeeds only if a pop happens in the same cycle.
module sv_uart_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    count_o = wptr_q - rptr_q;
    do_rd   = rd_i & ~empty_o;
    do_wr   = wr_i & (~full_o | do_rd);
    rdata_o = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (do_rd) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sv_uart_rx_ext.sv
// UART receiver: majority-sampled bits, runtime parity/stop config, break detect,
// error-tagged words buffered into an AXI-Stream FIFO.
module sv_uart_rx_ext
  import sv_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IN_PIPE    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  input  logic                  irx,
  input  logic [15:0]           idivider,
  input  logic [1:0]            iparity,
  input  logic                  istop2,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]            m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  obreak,
  output logic                  ooverflow,
  input  logic                  iclr_ovf
);

  localparam int unsigned IW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  logic [IN_PIPE-1:0]    sync_q;
  logic                  rxs;
  logic                  rxs_prev_q;
  rx_state_e             state_q;
  parity_e               par_q;
  logic [15:0]           div_q;
  logic [15:0]           cnt_q;
  logic                  stop2_q;
  logic                  s0_q;
  logic                  s1_q;
  logic                  par_bit_q;
  logic                  ferr_q;
  logic                  brk_q;
  logic                  wait_high_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [1:0]            user_q;
  logic                  push_q;
  logic                  brk_pulse_q;
  logic                  ovf_q;

  logic [15:0]           half;
  logic                  at_s0;
  logic                  at_s1;
  logic                  at_dec;
  logic                  at_last;
  logic                  maj;
  logic                  start_edge;
  logic                  perr;
  logic                  brk_now;
  logic                  brk_fin;
  logic                  finish;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  pop;
  logic [DATA_WIDTH+1:0] fifo_rdata;

  assign rxs = sync_q[IN_PIPE-1];

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[IN_PIPE-2:0], irx};
      rxs_prev_q <= rxs;
    end
  end

  always_comb begin
    half       = div_q >> 1;
    at_s0      = (cnt_q == half - 16'd1);
    at_s1      = (cnt_q == half);
    at_dec     = (cnt_q == half + 16'd1);
    at_last    = (cnt_q == div_q - 16'd1);
    maj        = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    start_edge = rxs_prev_q & ~rxs & ~wait_high_q;
    perr       = 1'b0;
    case (par_q)
      PAR_EVEN: perr = ^{shreg_q, par_bit_q};
      PAR_ODD:  perr = ~^{shreg_q, par_bit_q};
      default:  perr = 1'b0;
    endcase
    brk_now = (shreg_q == '0) & ~maj & ~((par_q != PAR_NONE) & par_bit_q);
    brk_fin = (state_q == ST_STOP) ? brk_now : brk_q;
    // Frame ends at the last stop-bit decision, not at bit end, so short stops still re-arm in time.
    finish  = at_dec & (((state_q == ST_STOP) & ~stop2_q) | (state_q == ST_STOP2));
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= ST_IDLE;
      par_q       <= PAR_NONE;
      div_q       <= 16'd4;
      cnt_q       <= '0;
      stop2_q     <= 1'b0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      par_bit_q   <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
      wait_high_q <= 1'b0;
      idx_q       <= '0;
      shreg_q     <= '0;
      word_q      <= '0;
      user_q      <= '0;
      push_q      <= 1'b0;
      brk_pulse_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      brk_pulse_q <= 1'b0;
      if (state_q != ST_IDLE) cnt_q <= at_last ? '0 : cnt_q + 16'd1;
      if (at_s0) s0_q <= rxs;
      if (at_s1) s1_q <= rxs;

      case (state_q)
        ST_IDLE: begin
          if (wait_high_q & rxs) wait_high_q <= 1'b0;
          if (start_edge) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            div_q   <= (idivider < 16'd4) ? 16'd4 : idivider;
            stop2_q <= istop2;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            case (iparity)
              2'd1:    par_q <= PAR_EVEN;
              2'd2:    par_q <= PAR_ODD;
              default: par_q <= PAR_NONE;
            endcase
          end
        end
        ST_START: begin
          if (at_dec & maj) state_q <= ST_IDLE;
          else if (at_last) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
          end
        end
        ST_DATA: begin
          if (at_dec) shreg_q <= {maj, shreg_q[DATA_WIDTH-1:1]};
          if (at_last) begin
            if (idx_q == LAST_IDX) state_q <= (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
            else                   idx_q   <= idx_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (at_dec)  par_bit_q <= maj;
          if (at_last) state_q   <= ST_STOP;
        end
        ST_STOP: begin
          if (at_dec) begin
            ferr_q <= ~maj;
            brk_q  <= brk_now;
          end
          if (at_last) state_q <= ST_STOP2;
        end
        ST_STOP2: ;
        default: state_q <= ST_IDLE;
      endcase

      if (finish) begin
        state_q                  <= ST_IDLE;
        push_q                   <= 1'b1;
        word_q                   <= shreg_q;
        user_q[TUSER_PARITY_ERR] <= perr;
        user_q[TUSER_FRAME_ERR]  <= ferr_q | ~maj;
        brk_pulse_q              <= brk_fin;
        wait_high_q              <= brk_fin;
      end
    end
  end

  assign pop = m_axis_tready & ~fifo_empty;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)                         ovf_q <= 1'b0;
    else if (push_q & fifo_full & ~pop)  ovf_q <= 1'b1;
    else if (iclr_ovf)                   ovf_q <= 1'b0;
  end

  sv_uart_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iclk),
    .rst_ni  (irst_n),
    .wr_i    (push_q),
    .wdata_i ({user_q, word_q}),
    .rd_i    (m_axis_tready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_axis_tdata  = fifo_rdata[DATA_WIDTH-1:0];
  assign m_axis_tuser  = fifo_rdata[DATA_WIDTH+1:DATA_WIDTH];
  assign m_axis_tvalid = (fifo_count != '0);
  assign obreak        = brk_pulse_q;
  assign ooverflow     = ovf_q;

endmodule

// File: tb/tb_sv_uart_rx_ext.sv
// Directed bench for sv_uart_rx_ext: frame table plus hand-written latency, glitch,
// overflow, break and mid-frame reset sequences.
module tb_sv_uart_rx_ext;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic        irx = 1'b1;
  logic [15:0] idivider = 16'd16;
  logic [1:0]  iparity = 2'd0;
  logic        istop2 = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        obreak;
  logic        ooverflow;
  logic        iclr_ovf = 1'b0;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned brk_cnt = 0;

  typedef struct {
    logic [15:0] div;
    logic [1:0]  par;
    logic        two;
    logic [7:0]  data;
    logic        pbit;
    logic        s1;
    logic        s2;
    logic [7:0]  exp_d;
    logic [1:0]  exp_u;
  } vec_t;

  vec_t vecs [11];

  sv_uart_rx_ext #(
    .DATA_WIDTH (8),
    .IN_PIPE    (3),
    .FIFO_DEPTH (4)
  ) dut (
    .iclk          (iclk),
    .irst_n        (irst_n),
    .irx           (irx),
    .idivider      (idivider),
    .iparity       (iparity),
    .istop2        (istop2),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .obreak        (obreak),
    .ooverflow     (ooverflow),
    .iclr_ovf      (iclr_ovf)
  );

  always #5 iclk = ~iclk;

  always @(negedge iclk) if (obreak) brk_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge iclk);
  endtask

  task automatic send_bit(input logic b, input int blen);
    irx = b;
    hold(blen);
  endtask

  task automatic send_frame(input vec_t v);
    int blen;
    blen     = (v.div < 16'd4) ? 4 : int'(v.div);
    idivider = v.div;
    iparity  = v.par;
    istop2   = v.two;
    send_bit(1'b0, blen);
    for (int i = 0; i < 8; i++) send_bit(v.data[i], blen);
    if (v.par == 2'd1 || v.par == 2'd2) send_bit(v.pbit, blen);
    send_bit(v.s1, blen);
    if (v.two) send_bit(v.s2, blen);
    send_bit(1'b1, 2 * blen);
  endtask

  task automatic expect_word(input string name, input logic [7:0] d, input logic [1:0] u);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (m_axis_tvalid) begin
        got = 1'b1;
        break;
      end
      @(negedge iclk);
    end
    check({name, " tvalid"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({name, " tdata"}, {24'd0, m_axis_tdata}, {24'd0, d});
      check({name, " tuser"}, {30'd0, m_axis_tuser}, {30'd0, u});
      m_axis_tready = 1'b1;
      @(negedge iclk);
      m_axis_tready = 1'b0;
    end
  endtask

  function automatic vec_t mk8n1(input logic [7:0] d);
    vec_t v;
    v = '{16'd16, 2'd0, 1'b0, d, 1'b0, 1'b1, 1'b1, d, 2'b00};
    return v;
  endfunction

  initial begin
    vecs[0]  = '{16'd16, 2'd0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 2'b00};
    vecs[1]  = '{16'd16, 2'd1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 2'b10};
    vecs[2]  = '{16'd16, 2'd2, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 2'b00};
    vecs[3]  = '{16'd16, 2'd0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h55, 2'b01};
    vecs[4]  = '{16'd16, 2'd0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 2'b00};
    vecs[5]  = '{16'd16, 2'd1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 2'b00};
    vecs[6]  = '{16'd16, 2'd2, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 2'b10};
    vecs[7]  = '{16'd16, 2'd3, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 8'h0F, 2'b00};
    vecs[8]  = '{16'd3,  2'd0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 2'b00};
    vecs[9]  = '{16'd16, 2'd0, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, 8'h7E, 2'b01};
    vecs[10] = '{16'd5,  2'd1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 2'b00};

    hold(3);
    check("reset outputs", {20'd0, m_axis_tvalid, obreak, ooverflow, m_axis_tdata, m_axis_tuser},
          32'd0);
    irst_n = 1'b1;
    hold(4);
    check("post-reset tvalid", {31'd0, m_axis_tvalid}, 32'd0);

    // Latency: 3 sync stages + decision at cnt=9 of the stop bit + push + FIFO count update.
    idivider = 16'd16; iparity = 2'd0; istop2 = 1'b0;
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a5;
      a5 = 8'hA5;
      send_bit(a5[i], 16);
    end
    irx = 1'b1;
    repeat (14) @(posedge iclk);
    @(negedge iclk);
    check("latency tvalid early", {31'd0, m_axis_tvalid}, 32'd0);
    @(posedge iclk);
    @(negedge iclk);
    check("latency tvalid on time", {31'd0, m_axis_tvalid}, 32'd1);
    hold(32);
    expect_word("latency word", 8'hA5, 2'b00);

    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i]);
      expect_word($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_u);
    end
    check("no break in table", brk_cnt, 32'd0);

    idivider = 16'd16; iparity = 2'd0; istop2 = 1'b0;
    irx = 1'b0;
    hold(3);
    irx = 1'b1;
    hold(64);
    check("glitch no push", {31'd0, m_axis_tvalid}, 32'd0);
    send_frame(mk8n1(8'h81));
    expect_word("after glitch", 8'h81, 2'b00);

    for (int k = 1; k <= 4; k++) send_frame(mk8n1(8'(k)));
    check("four held no ovf", {31'd0, ooverflow}, 32'd0);
    send_frame(mk8n1(8'h05));
    check("fifth sets ovf", {31'd0, ooverflow}, 32'd1);
    for (int k = 1; k <= 4; k++) expect_word($sformatf("drain%0d", k), 8'(k), 2'b00);
    check("drained empty", {31'd0, m_axis_tvalid}, 32'd0);
    check("ovf sticky", {31'd0, ooverflow}, 32'd1);
    iclr_ovf = 1'b1;
    @(negedge iclk);
    iclr_ovf = 1'b0;
    @(negedge iclk);
    check("ovf cleared", {31'd0, ooverflow}, 32'd0);

    idivider = 16'd16; iparity = 2'd0; istop2 = 1'b0;
    irx = 1'b0;
    hold(192);
    irx = 1'b1;
    hold(48);
    check("break pulse count", brk_cnt, 32'd1);
    expect_word("break word", 8'h00, 2'b01);
    hold(4);
    check("no frame after break", {31'd0, m_axis_tvalid}, 32'd0);
    send_frame(mk8n1(8'h42));
    expect_word("rearm after break", 8'h42, 2'b00);

    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 8);
    irst_n = 1'b0;
    hold(2);
    check("mid-frame reset tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    irst_n = 1'b1;
    hold(16 * 12);
    check("no word after reset", {31'd0, m_axis_tvalid}, 32'd0);
    check("no break after reset", brk_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sv_uart_rx_ext.md
Name: sv_uart_rx_ext

Overview:
Parametrised UART receiver: configurable data width, runtime parity and stop-bit mode, 3-point majority sampling, false-start rejection. Reports parity, framing and break errors, and buffers received words in a small FIFO. Output is an AXI-Stream master with error flags in tuser. Sits behind the pad synchroniser boundary and in front of the host-side AXIS fabric.

Parameters:
DATA_WIDTH, 8, data bits per frame, legal 5..9
IN_PIPE, 3, synchroniser stages on irx, >=2
FIFO_DEPTH, 4, output FIFO words, power of two, >=2

Ports:
iclk  in  1  sole clock
irst_n  in  1  reset, asynchronous, active-low
irx  in  1  serial line, idle high, asynchronous
idivider  in  16  clocks per bit; values <4 treated as 4
iparity  in  2  0 none, 1 even, 2 odd, 3 treated as none
istop2  in  1  1 = two stop bits checked
m_axis_tdata  out  DATA_WIDTH  received word, LSB first on line
m_axis_tuser  out  2  {parity_err, frame_err} of this word
m_axis_tvalid  out  1  FIFO not empty
m_axis_tready  in  1  consumer ready
obreak  out  1  one-cycle pulse on break detection
ooverflow  out  1  sticky: word dropped on full FIFO
iclr_ovf  in  1  clears ooverflow

Behaviour:
- Reset: one clock, reset is asynchronous and active-low. All outputs 0, synchroniser flops reset to 1 (idle line), FSM IDLE, FIFO empty.
- idivider, iparity and istop2 are latched at start detection and held for the whole frame.
- Synchronised line rxs = last stage of the IN_PIPE chain. A start edge is rxs 1->0, seen only in IDLE.
- Bit timer cnt counts 0..D-1 with D = latched divider. H = D>>1. Samples are taken at cnt = H-1, H, H+1. The bit value is the 2-of-3 majority, decided at cnt = H+1.
- FSM: IDLE -> START on start edge, cnt cleared. START: majority 1 -> IDLE (glitch, nothing pushed); majority 0 -> DATA at cnt wrap. DATA: DATA_WIDTH bits shifted LSB first -> PARITY if enabled, else STOP. PARITY: one bit compared with even/odd of data -> STOP. STOP: first stop bit, then STOP2 if istop2 latched. STOP2: -> IDLE.
- frame_err = any checked stop bit sampled 0.
- Early return: after the last stop-bit decision, the FSM returns to IDLE immediately (at cnt = H+1, not at bit end), so back-to-back frames with a short stop are accepted.
- Push: the word and flags are written to the FIFO on the cycle after the last stop-bit decision.
- Break: all data bits 0, parity bit (if any) 0 and first stop 0 -> obreak pulses at push time. The word is still pushed with frame_err = 1. The FSM then waits in IDLE for rxs = 1 before re-arming start detection.
- Latency: push at cycle P; tvalid = 1 at P+1 (registered count).
- FIFO: transfer on tvalid & tready. Push onto a full FIFO drops the new word and sets ooverflow. If push and pop occur in the same cycle while full, both succeed. A push to an empty FIFO becomes visible the next cycle (no same-cycle bypass). tdata/tuser are stable while tvalid & ~tready.
- ooverflow: iclr_ovf clears it. If iclr_ovf and a new overflow occur in the same cycle, set wins.
- Reset mid-frame aborts the frame; no partial word is ever pushed.
- Width rules: cnt is 16 bits, bit index is $clog2(DATA_WIDTH+1), FIFO pointers are $clog2(FIFO_DEPTH)+1 bits with wrap bit.

Decomposition:
- Package sv_uart_pkg: parity enum (PAR_NONE, PAR_EVEN, PAR_ODD), rx FSM state enum, tuser bit index constants.
- One sub-module: sv_uart_fifo (sync FIFO, DATA_WIDTH+2 bits, FIFO_DEPTH; full/empty/count outputs), reusable by the TX side.

Test Plan:
- idivider=16, 8N1, send 0xA5, tready=1 -> one beat, tdata=0xA5, tuser=00, tvalid one cycle after the stop decision.
- idivider=16, even parity, send 0x3C with parity bit 1 -> tdata=0x3C, tuser=10; same frame with odd parity and the same bit -> tuser=00.
- 8N2, send 0x55 with second stop 0 -> tuser=01; with both stops 1 -> tuser=00.
- irx low for 3 clocks at idivider=16 -> no push, FSM back in IDLE; following frame 0x81 received correctly.
- tready=0, send 0x01..0x05 -> 4 words held, ooverflow=1; drain yields 0x01,0x02,0x03,0x04; pulse iclr_ovf -> ooverflow=0.
- Line low for 12 bit times -> one word 0x00 with tuser=01, obreak pulses once; no further frame until the line returns high. Separately, assert irst_n low mid-DATA -> tvalid=0, no word after release.
